mips_mc_core: RTL and testbench

//  Parametrised multi-cycle MIPS32-subset CPU core: IF/ID/EX/ME/WB over a one-hot stage register.

---
 rtl/mips_mc_core.sv | 190 +++++++++++++++++++
 tb/tb_mips_mc_core.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_core.sv
// rtl/mips_mc_core.sv - multi-cycle MIPS32-subset core with req/ack instruction and data ports
module mips_mc_core #(
  parameter logic [31:0] PC_INIT   = 32'h8002_0000,
  parameter logic [31:0] SP_INIT   = 32'h8012_0000,
  parameter logic [31:0] RA_INIT   = 32'h0000_0000,
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic        instr_ack,
  input  logic [31:0] instr_in,
  output logic [31:0] data_addr,
  output logic [31:0] data_out,
  output logic        data_rd_wr,
  output logic        data_req,
  input  logic        data_ack,
  input  logic [31:0] data_in,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [4:0] {
    S_IF = 5'b00001,
    S_ID = 5'b00010,
    S_EX = 5'b00100,
    S_ME = 5'b01000,
    S_WB = 5'b10000
  } stage_t;

  stage_t stage, stage_nx;

  logic [31:0] pc, ir, a_q, b_q, res_q;
  logic [31:0] rf [32];
  logic        wb_en_q, halt_pend;
  logic [4:0]  dst_q;

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sh, dst;
  logic [31:0] sext, zext, pc_plus4, a_rd, b_rd, alu, next_pc, mem_addr;
  logic        legal, is_mem, is_load, is_jump, wb_en;
  logic [1:0]  lo_sum;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign sh       = ir[10:6];
  assign fn       = ir[5:0];
  assign sext     = {{16{ir[15]}}, ir[15:0]};
  assign zext     = {16'h0000, ir[15:0]};
  assign pc_plus4 = pc + 32'd4;
  assign a_rd     = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign b_rd     = (rt == 5'd0) ? 32'h0 : rf[rt];
  assign mem_addr = a_q + sext;
  // Low two address bits only depend on the low operand bits, so misalignment is known in ID.
  assign lo_sum   = a_rd[1:0] + ir[1:0];
  assign instr_addr = pc;

  always_comb begin
    legal   = 1'b1;
    is_mem  = 1'b0;
    is_load = 1'b0;
    is_jump = 1'b0;
    wb_en   = 1'b0;
    dst     = rt;
    alu     = 32'h0;
    next_pc = pc_plus4;
    case (op)
      6'h00: begin
        dst   = rd;
        wb_en = 1'b1;
        case (fn)
          6'h21: alu = a_q + b_q;
          6'h23: alu = a_q - b_q;
          6'h24: alu = a_q & b_q;
          6'h25: alu = a_q | b_q;
          6'h26: alu = a_q ^ b_q;
          6'h2A: alu = {31'h0, $signed(a_q) < $signed(b_q)};
          6'h2B: alu = {31'h0, a_q < b_q};
          6'h00: alu = b_q << sh;
          6'h02: alu = b_q >> sh;
          6'h08: begin
            wb_en   = 1'b0;
            is_jump = 1'b1;
            next_pc = a_q;
          end
          default: begin
            legal = 1'b0;
            wb_en = 1'b0;
          end
        endcase
      end
      6'h09: begin wb_en = 1'b1; alu = a_q + sext; end
      6'h0A: begin wb_en = 1'b1; alu = {31'h0, $signed(a_q) < $signed(sext)}; end
      6'h0B: begin wb_en = 1'b1; alu = {31'h0, a_q < sext}; end
      6'h0C: begin wb_en = 1'b1; alu = a_q & zext; end
      6'h0D: begin wb_en = 1'b1; alu = a_q | zext; end
      6'h0E: begin wb_en = 1'b1; alu = a_q ^ zext; end
      6'h0F: begin wb_en = 1'b1; alu = {ir[15:0], 16'h0000}; end
      6'h23: begin is_mem = 1'b1; is_load = 1'b1; wb_en = 1'b1; end
      6'h2B: is_mem = 1'b1;
      6'h04: if (a_q == b_q) next_pc = pc_plus4 + {sext[29:0], 2'b00};
      6'h05: if (a_q != b_q) next_pc = pc_plus4 + {sext[29:0], 2'b00};
      6'h02: begin
        is_jump = 1'b1;
        next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
      end
      6'h03: begin
        is_jump = 1'b1;
        next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
        wb_en   = 1'b1;
        dst     = 5'd31;
        alu     = pc_plus4;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    stage_nx  = stage;
    instr_req = 1'b0;
    data_req  = 1'b0;
    illegal   = 1'b0;
    case (stage)
      S_IF: if (!halted && !reset) begin
        instr_req = 1'b1;
        if (instr_ack) stage_nx = S_ID;
      end
      S_ID: begin
        illegal  = !legal || (is_mem && lo_sum != 2'b00);
        stage_nx = S_EX;
      end
      S_EX: stage_nx = is_mem ? S_ME : S_WB;
      S_ME: begin
        data_req = 1'b1;
        if (data_ack) stage_nx = S_WB;
      end
      S_WB:    stage_nx = S_IF;
      default: stage_nx = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage      <= S_IF;
      pc         <= PC_INIT;
      ir         <= 32'h0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      res_q      <= 32'h0;
      wb_en_q    <= 1'b0;
      dst_q      <= 5'd0;
      halt_pend  <= 1'b0;
      halted     <= 1'b0;
      data_addr  <= SP_INIT;
      data_out   <= 32'h0;
      data_rd_wr <= 1'b1;
      for (int i = 0; i < 32; i++)
        rf[i] <= (i == 29) ? SP_INIT : ((i == 31) ? RA_INIT : 32'h0);
    end else begin
      stage <= stage_nx;
      case (stage)
        S_IF: if (instr_req && instr_ack) ir <= instr_in;
        S_ID: begin
          a_q <= a_rd;
          b_q <= b_rd;
        end
        S_EX: begin
          pc        <= next_pc;
          res_q     <= alu;
          wb_en_q   <= wb_en;
          dst_q     <= dst;
          halt_pend <= is_jump && (next_pc == HALT_ADDR);
          if (is_mem) begin
            data_addr  <= mem_addr & ~32'h3;
            data_rd_wr <= is_load;
            data_out   <= b_q;
          end
        end
        S_ME: if (data_ack && is_load) res_q <= data_in;
        S_WB: begin
          if (wb_en_q && dst_q != 5'd0) rf[dst_q] <= res_q;
          if (halt_pend) halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mc_core.sv
// tb/tb_mips_mc_core.sv - randomized scoreboard bench for mips_mc_core against an instruction-level model
module tb_mips_mc_core;
  localparam logic [31:0] PC_INIT   = 32'h8002_0000;
  localparam logic [31:0] SP_INIT   = 32'h8012_0000;
  localparam logic [31:0] RA_INIT   = 32'h0000_0000;
  localparam logic [31:0] HALT_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_addr, instr_in = 32'h0;
  logic        instr_req, instr_ack = 1'b0;
  logic [31:0] data_addr, data_out, data_in = 32'h0;
  logic        data_rd_wr, data_req, data_ack = 1'b0;
  logic        halted, illegal;

  always #5 clk = ~clk;

  mips_mc_core #(.PC_INIT(PC_INIT), .SP_INIT(SP_INIT), .RA_INIT(RA_INIT), .HALT_ADDR(HALT_ADDR)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack), .instr_in(instr_in),
    .data_addr(data_addr), .data_out(data_out), .data_rd_wr(data_rd_wr), .data_req(data_req),
    .data_ack(data_ack), .data_in(data_in), .halted(halted), .illegal(illegal)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Instruction-level reference model
  typedef struct packed { logic [31:0] addr; logic rd; logic [31:0] wdata; } dacc_t;
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  bit          m_halted;
  logic [31:0] m_dmem [logic [31:0]];
  logic [31:0] b_dmem [logic [31:0]];
  logic [31:0] exp_fetch [$];
  dacc_t       exp_data [$];
  logic [31:0] exp_ill [$];
  logic [31:0] directed [$];
  bit          auto_on = 1'b0;

  function automatic logic [31:0] dm_init(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[29] = SP_INIT;
    m_reg[31] = RA_INIT;
    m_pc = PC_INIT;
    m_halted = 1'b0;
    m_dmem.delete();
    exp_fetch.delete();
    exp_data.delete();
    exp_ill.delete();
    exp_fetch.push_back(PC_INIT);
  endtask

  task automatic model_step(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    logic [31:0] se, ze, a, b, pc4, npc, val, addr;
    bit          wr, ill, jmp;
    dacc_t       d;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'h0000, ins[15:0]};
    a = m_reg[rs]; b = m_reg[rt];
    pc4 = m_pc + 32'd4; npc = pc4;
    wr = 1'b0; ill = 1'b0; jmp = 1'b0; dst = rt; val = 32'h0;
    case (op)
      6'h00: begin
        dst = rd; wr = 1'b1;
        case (fn)
          6'h21: val = a + b;
          6'h23: val = a - b;
          6'h24: val = a & b;
          6'h25: val = a | b;
          6'h26: val = a ^ b;
          6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: val = (a < b) ? 32'd1 : 32'd0;
          6'h00: val = b << sh;
          6'h02: val = b >> sh;
          6'h08: begin wr = 1'b0; jmp = 1'b1; npc = a; end
          default: begin wr = 1'b0; ill = 1'b1; end
        endcase
      end
      6'h09: begin wr = 1'b1; val = a + se; end
      6'h0A: begin wr = 1'b1; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; val = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; val = a & ze; end
      6'h0D: begin wr = 1'b1; val = a | ze; end
      6'h0E: begin wr = 1'b1; val = a ^ ze; end
      6'h0F: begin wr = 1'b1; val = ze << 16; end
      6'h23, 6'h2B: begin
        addr = a + se;
        if (addr[1:0] != 2'b00) ill = 1'b1;
        addr[1:0] = 2'b00;
        d.addr = addr; d.rd = (op == 6'h23); d.wdata = b;
        exp_data.push_back(d);
        if (op == 6'h23) begin
          wr = 1'b1;
          val = m_dmem.exists(addr) ? m_dmem[addr] : dm_init(addr);
        end else begin
          m_dmem[addr] = b;
        end
      end
      6'h04: if (a == b) npc = pc4 + (se << 2);
      6'h05: if (a != b) npc = pc4 + (se << 2);
      6'h02: begin jmp = 1'b1; npc = {pc4[31:28], ins[25:0], 2'b00}; end
      6'h03: begin
        jmp = 1'b1; npc = {pc4[31:28], ins[25:0], 2'b00};
        wr = 1'b1; dst = 5'd31; val = pc4;
      end
      default: ill = 1'b1;
    endcase
    if (ill) exp_ill.push_back(m_pc);
    if (wr && dst != 5'd0) m_reg[dst] = val;
    if (jmp && npc == HALT_ADDR) m_halted = 1'b1;
    else exp_fetch.push_back(npc);
    m_pc = npc;
  endtask

  // Random instruction generator
  function automatic logic [4:0] pick_src();
    int k;
    k = $urandom_range(0, 15);
    if (k < 13) return 5'(k);
    if (k < 15) return 5'd29;
    return 5'd31;
  endfunction

  function automatic logic [4:0] pick_dst();
    return 5'($urandom_range(1, 12));
  endfunction

  function automatic logic [31:0] gen_random();
    int          cls;
    logic [5:0]  r_fn [9];
    logic [5:0]  i_op [7];
    logic [15:0] off;
    cls  = $urandom_range(0, 99);
    r_fn = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h00, 6'h02};
    i_op = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    off  = 16'($urandom_range(0, 16) * 4) - 16'd32;
    if ($urandom_range(0, 7) == 0) off = off + 16'($urandom_range(1, 3));
    if (cls < 35) return {6'h00, pick_src(), pick_src(), pick_dst(), 5'($urandom), r_fn[$urandom_range(0, 8)]};
    if (cls < 60) return {i_op[$urandom_range(0, 6)], pick_src(), pick_dst(), 16'($urandom)};
    if (cls < 72) return {6'h23, 5'd29, pick_dst(), off};
    if (cls < 82) return {6'h2B, 5'd29, pick_src(), off};
    if (cls < 90) return {($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, pick_src(), pick_src(),
                          16'($urandom_range(0, 12)) - 16'd4};
    if (cls < 94) return {6'h02, 26'($urandom)};
    if (cls < 97) return {6'h03, 26'($urandom)};
    if (cls < 99) return {6'h3F, 26'($urandom)};
    return {6'h00, 20'($urandom), 6'h01};
  endfunction

  // Scoreboard monitor
  logic        last_ireq = 1'b0;
  logic        last_ill = 1'b0;
  logic [31:0] cur_fetch = 32'h0;

  always @(negedge clk) begin
    if (auto_on && !reset) begin
      if (instr_req && !last_ireq) begin
        if (exp_fetch.size() == 0) fail_now("unexpected_fetch", instr_addr);
        else begin
          check("fetch_addr", instr_addr, exp_fetch[0]);
          void'(exp_fetch.pop_front());
        end
      end
      if (data_req) begin
        if (exp_data.size() == 0) fail_now("unexpected_data_req", data_addr);
        else begin
          check("data_addr", data_addr, exp_data[0].addr);
          check("data_rd_wr", 32'(data_rd_wr), 32'(exp_data[0].rd));
          check("data_out", data_out, exp_data[0].wdata);
          if (data_ack) void'(exp_data.pop_front());
        end
      end
      if (illegal) begin
        if (last_ill) fail_now("illegal_wide_pulse", cur_fetch);
        else if (exp_ill.size() == 0) fail_now("unexpected_illegal", cur_fetch);
        else begin
          check("illegal_pc", cur_fetch, exp_ill[0]);
          void'(exp_ill.pop_front());
        end
      end
    end
    last_ireq <= instr_req;
    last_ill  <= illegal;
    if (instr_req) cur_fetch <= instr_addr;
  end

  // Data memory responder with random wait states
  initial forever begin
    @(posedge clk); #1;
    if (auto_on && data_req) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      data_ack = 1'b1;
      if (data_rd_wr) data_in = b_dmem.exists(data_addr) ? b_dmem[data_addr] : dm_init(data_addr);
      else b_dmem[data_addr] = data_out;
      @(posedge clk); #1;
      data_ack = 1'b0;
      data_in = $urandom;
    end
  end

  task automatic wait_ireq(output int n);
    n = 0;
    while (!instr_req && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic wait_dreq(output int n);
    n = 0;
    while (!data_req && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  task automatic run_program(input int n_rand);
    int          issued;
    int          n;
    bit          ending;
    logic [31:0] ins;
    issued = 0;
    ending = 1'b0;
    while (!m_halted) begin
      wait_ireq(n);
      if (!instr_req) begin
        fail_now("fetch_timeout", m_pc);
        return;
      end
      if (directed.size() == 0 && issued >= n_rand && !ending) begin
        directed.push_back(32'h241F0000);
        directed.push_back(32'h03E00008);
        ending = 1'b1;
      end
      if (directed.size() > 0) ins = directed.pop_front();
      else begin
        ins = gen_random();
        issued++;
      end
      model_step(ins);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      instr_in = ins;
      instr_ack = 1'b1;
      @(posedge clk); #1;
      instr_ack = 1'b0;
      instr_in = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int held;
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_addr", instr_addr, PC_INIT);
    check("rst_instr_req", 32'(instr_req), 32'd0);
    check("rst_data_req", 32'(data_req), 32'd0);
    check("rst_data_rd_wr", 32'(data_rd_wr), 32'd1);
    check("rst_data_addr", data_addr, SP_INIT);
    check("rst_data_out", data_out, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    // Directed: fetch latency, store hold with late ack, reset mid-ME
    reset = 1'b0;
    wait_ireq(n);
    check("first_fetch", instr_addr, 32'h8002_0000);
    instr_in = 32'h2402FFFF;
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    n = 1;
    while (!instr_req && n < 50) begin @(posedge clk); #1; n++; end
    check("alu_latency", 32'(n), 32'd4);
    check("second_fetch", instr_addr, 32'h8002_0004);
    instr_in = 32'hAFA2FFFC;
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    wait_dreq(n);
    check("sw_addr", data_addr, 32'h8011_FFFC);
    check("sw_rd_wr", 32'(data_rd_wr), 32'd0);
    check("sw_data", data_out, 32'hFFFF_FFFF);
    held = 0;
    repeat (3) begin
      if (data_req) held++;
      @(posedge clk); #1;
    end
    if (data_req) held++;
    check("sw_addr_held", data_addr, 32'h8011_FFFC);
    check("sw_data_held", data_out, 32'hFFFF_FFFF);
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
    check("sw_hold_cycles", 32'(held), 32'd4);
    check("sw_req_drop", 32'(data_req), 32'd0);
    wait_ireq(n);
    check("third_fetch", instr_addr, 32'h8002_0008);
    instr_in = 32'h8FA4FFFC;
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    wait_dreq(n);
    check("lw_req", 32'(data_req), 32'd1);
    check("lw_rd_wr", 32'(data_rd_wr), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("midme_data_req", 32'(data_req), 32'd0);
    check("midme_instr_req", 32'(instr_req), 32'd0);
    check("midme_data_addr", data_addr, SP_INIT);
    data_ack = 1'b1;
    data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    data_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ireq(n);
    check("refetch_addr", instr_addr, PC_INIT);
    instr_in = 32'hAC1D0000;
    instr_ack = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    wait_dreq(n);
    check("sp_after_reset", data_out, SP_INIT);
    check("sp_store_addr", data_addr, 32'h0);
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;

    // Randomized program checked by the scoreboard
    reset = 1'b1;
    model_reset();
    b_dmem.delete();
    directed.delete();
    directed = '{32'h2402FFFF, 32'h00021902, 32'hAFA2FFFC, 32'h8FA4FFFC, 32'h14400002, 32'h10400002,
                 32'h0C008010, 32'hAFBF0000, 32'hAFA30004, 32'hAFA40008, 32'hFC000000};
    repeat (2) @(posedge clk);
    #1;
    auto_on = 1'b1;
    reset = 1'b0;
    run_program(400);

    n = 0;
    while (!halted && n < 20) begin @(posedge clk); #1; n++; end
    check("halted", 32'(halted), 32'd1);
    held = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (instr_req || data_req) held++;
    end
    check("no_req_after_halt", 32'(held), 32'd0);
    auto_on = 1'b0;
    check("pending_fetch", 32'(exp_fetch.size()), 32'd0);
    check("pending_data", 32'(exp_data.size()), 32'd0);
    check("pending_illegal", 32'(exp_ill.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
